// File: rtl/gcd_calculator.sv
// rtl/gcd_calculator.sv - subtractive Euclid GCD engine, one subtraction per clock
// Optional macro GCD_START_ABORT_EN: start during CALC reloads operands and restarts.
module gcd_calculator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] P,
  input  logic [N-1:0] Q,
  input  logic         start,
  output logic [N-1:0] R,
  output logic         valid,
  output logic [1:0]   State_Y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] r_q, r_d;
  logic         valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = P;
          b_d     = Q;
          valid_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef GCD_START_ABORT_EN
        if (start) begin
          a_d     = P;
          b_d     = Q;
          valid_d = 1'b0;
        end else
`endif
        // A|B covers the zero-operand and equal-operand terminals in one expression
        if (a_q == '0 || b_q == '0 || a_q == b_q) begin
          r_d     = a_q | b_q;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      DONE: begin
        if (start) begin
          a_d     = P;
          b_d     = Q;
          valid_d = 1'b0;
          state_d = CALC;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign R       = r_q;
  assign valid   = valid_q;
  assign State_Y = state_q;

endmodule

// File: tb/tb_gcd_calculator.sv
// tb/tb_gcd_calculator.sv - directed self-checking bench for gcd_calculator
module tb_gcd_calculator;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] P;
  logic [N-1:0] Q;
  logic         start;
  logic [N-1:0] R;
  logic         valid;
  logic [1:0]   State_Y;

  int tests_run;
  int failures;

  gcd_calculator #(.N(N)) dut (
    .clk(clk), .rst(rst), .P(P), .Q(Q), .start(start),
    .R(R), .valid(valid), .State_Y(State_Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one edge, then counts edges (including the load edge) until valid.
  task automatic run_gcd(input logic [N-1:0] p, input logic [N-1:0] q, output int edges);
    @(negedge clk);
    P = p;
    Q = q;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (!valid && edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    P = '0;
    Q = '0;
    #12;
    tests_run++;
    if (R !== 8'd0 || valid !== 1'b0 || State_Y !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: R=%0d valid=%0b state=%0d, want 0 0 0", R, valid, State_Y);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (R !== 8'd0 || valid !== 1'b0 || State_Y !== 2'd0) begin
      failures++;
      $display("FAIL idle_hold: R=%0d valid=%0b state=%0d, want 0 0 0", R, valid, State_Y);
    end
  endtask

  task automatic test_basic();
    int edges;
    @(negedge clk);
    P = 8'd24;
    Q = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests_run++;
    if (State_Y !== 2'd1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL load_to_calc: state=%0d valid=%0b, want 1 0", State_Y, valid);
    end
    edges = 1;
    while (!valid && edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests_run++;
    if (edges !== 10 || R !== 8'd1 || State_Y !== 2'd2) begin
      failures++;
      $display("FAIL gcd_24_13: edges=%0d R=%0d state=%0d, want 10 1 2", edges, R, State_Y);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (R !== 8'd1 || valid !== 1'b1 || State_Y !== 2'd2) begin
      failures++;
      $display("FAIL done_hold: R=%0d valid=%0b state=%0d, want 1 1 2", R, valid, State_Y);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    run_gcd(8'd48, 8'd18, edges);
    tests_run++;
    if (edges !== 6 || R !== 8'd6 || valid !== 1'b1) begin
      failures++;
      $display("FAIL gcd_48_18: edges=%0d R=%0d valid=%0b, want 6 6 1", edges, R, valid);
    end
    @(negedge clk);
    P = 8'd12;
    Q = 8'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || State_Y !== 2'd1) begin
      failures++;
      $display("FAIL restart_drop: valid=%0b state=%0d, want 0 1", valid, State_Y);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (valid !== 1'b1 || R !== 8'd12 || State_Y !== 2'd2) begin
      failures++;
      $display("FAIL gcd_12_12: valid=%0b R=%0d state=%0d, want 1 12 2", valid, R, State_Y);
    end
  endtask

  task automatic test_zero_operands();
    int edges;
    logic [N-1:0] pv [3];
    logic [N-1:0] qv [3];
    logic [N-1:0] rv [3];
    pv = '{8'd0, 8'd35, 8'd0};
    qv = '{8'd35, 8'd0, 8'd0};
    rv = '{8'd35, 8'd35, 8'd0};
    for (int i = 0; i < 3; i++) begin
      run_gcd(pv[i], qv[i], edges);
      tests_run++;
      if (edges !== 2 || R !== rv[i] || valid !== 1'b1) begin
        failures++;
        $display("FAIL zero_op_%0d: edges=%0d R=%0d valid=%0b, want 2 %0d 1", i, edges, R, valid, rv[i]);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int edges;
    @(negedge clk);
    P = 8'd255;
    Q = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (State_Y !== 2'd1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_calc_state: state=%0d valid=%0b, want 1 0", State_Y, valid);
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (State_Y !== 2'd0 || valid !== 1'b0 || R !== 8'd0) begin
      failures++;
      $display("FAIL async_abort: state=%0d valid=%0b R=%0d, want 0 0 0", State_Y, valid, R);
    end
    @(negedge clk);
    rst = 1'b0;
    run_gcd(8'd255, 8'd1, edges);
    tests_run++;
    if (edges !== 256 || R !== 8'd1) begin
      failures++;
      $display("FAIL worst_case: edges=%0d R=%0d, want 256 1", edges, R);
    end
  endtask

  task automatic test_start_in_calc();
    int edges;
    logic [N-1:0] want;
`ifdef GCD_START_ABORT_EN
    want = 8'd10;
`else
    want = 8'd1;
`endif
    @(negedge clk);
    P = 8'd24;
    Q = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    P = 8'd30;
    Q = 8'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || State_Y !== 2'd1) begin
      failures++;
      $display("FAIL start_in_calc_state: valid=%0b state=%0d, want 0 1", valid, State_Y);
    end
    edges = 0;
    while (!valid && edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests_run++;
    if (valid !== 1'b1 || R !== want) begin
      failures++;
      $display("FAIL start_in_calc: valid=%0b R=%0d, want 1 %0d", valid, R, want);
    end
  endtask

  initial begin
    tests_run = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_operands();
    test_reset_mid_calc();
    test_start_in_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
